// File: rtl/estimador_state_update.sv
// Observer state-update stage: x_next = sat(A*xhat + B*u + temp2) in Q16.16,
// computed row by row on one shared 32x32 signed multiplier. The new state
// vector is committed in a single cycle once all three rows are finished.
module estimador_state_update #(
  parameter logic [287:0] A_COEFS = {32'h00010000, 32'h00000000, 32'h00000000,
                                     32'h00000000, 32'h00010000, 32'h00000000,
                                     32'h00000000, 32'h00000000, 32'h00010000},
  parameter logic [95:0]  B_COEFS = 96'h0
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [31:0] temp2_0,
  input  logic [31:0] temp2_1,
  input  logic [31:0] temp2_2,
  input  logic [31:0] u_in,
  input  logic        init_vld,
  input  logic [31:0] init_0,
  input  logic [31:0] init_1,
  input  logic [31:0] init_2,
  output logic [31:0] xhat_0,
  output logic [31:0] xhat_1,
  output logic [31:0] xhat_2
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MAC    = 3'd1;
  localparam logic [2:0] S_FIN    = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [52:0] R_MAX = 53'sd2147483647;
  localparam logic signed [52:0] R_MIN = -53'sd2147483648;

  logic signed [31:0] a_w [9];
  logic signed [31:0] b_w [3];

  logic [2:0]         state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [1:0]         term_q, term_d;
  logic signed [67:0] acc_q, acc_d;
  logic [31:0]        nbuf_q [3];
  logic [31:0]        nbuf_d [3];
  logic [31:0]        xhat_q [3];
  logic [31:0]        xhat_d [3];
  logic [31:0]        t2_q [3];
  logic [31:0]        t2_d [3];
  logic [31:0]        u_q, u_d;

  logic [3:0]         a_idx;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [31:0]        t2_row;
  logic signed [67:0] fin_t;
  logic signed [52:0] fin_r;
  logic [31:0]        fin_res;
  logic               ready_c;
  logic               unused_low_bits;

  // Unpack the coefficient parameters into word arrays (constants after elaboration)
  for (genvar k = 0; k < 9; k++) begin : g_a_words
    assign a_w[k] = A_COEFS[32*k +: 32];
  end
  for (genvar k = 0; k < 3; k++) begin : g_b_words
    assign b_w[k] = B_COEFS[32*k +: 32];
  end

  // Row-major coefficient index row*3 + term, built from shifts and adds
  assign a_idx = {2'b00, row_q} + {1'b0, row_q, 1'b0} + {2'b00, term_q};

  // Multiplier operand select: state terms 0..2 use A and the old xhat, term 3 uses B and u
  always_comb begin
    mul_a = b_w[row_q];
    mul_b = u_q;
    if (term_q != 2'd3) begin
      mul_a = a_w[a_idx];
      mul_b = xhat_q[term_q];
    end
  end

  assign prod = mul_a * mul_b;

  // Row finish: add the shifted correction term, round half up, saturate to 32 bits
  always_comb begin
    t2_row  = t2_q[row_q];
    fin_t   = acc_q + {{20{t2_row[31]}}, t2_row, 16'h0000};
    fin_r   = {fin_t[67], fin_t[67:16]} + {52'd0, fin_t[15]};
    fin_res = fin_r[31:0];
    if (fin_r > R_MAX) begin
      fin_res = 32'h7FFFFFFF;
    end else if (fin_r < R_MIN) begin
      fin_res = 32'h80000000;
    end
  end

  // Fraction bits below the rounding bit are intentionally discarded
  assign unused_low_bits = ^fin_t[14:0];

  // Row/term sequencing, accumulation and state commit
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    term_d  = term_q;
    acc_d   = acc_q;
    nbuf_d  = nbuf_q;
    xhat_d  = xhat_q;
    t2_d    = t2_q;
    u_d     = u_q;
    ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_vld) begin
          xhat_d[0] = init_0;
          xhat_d[1] = init_1;
          xhat_d[2] = init_2;
        end else if (ap_start) begin
          ready_c = 1'b1;
          t2_d[0] = temp2_0;
          t2_d[1] = temp2_1;
          t2_d[2] = temp2_2;
          u_d     = u_in;
          acc_d   = '0;
          row_d   = 2'd0;
          term_d  = 2'd0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d  = acc_q + {{4{prod[63]}}, prod};
        term_d = term_q + 2'd1;
        if (term_q == 2'd3) begin
          term_d  = 2'd0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        nbuf_d[row_q] = fin_res;
        acc_d         = '0;
        term_d        = 2'd0;
        if (row_q == 2'd2) begin
          state_d = S_COMMIT;
        end else begin
          row_d   = row_q + 2'd1;
          state_d = S_MAC;
        end
      end
      S_COMMIT: begin
        xhat_d  = nbuf_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any update in flight
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      nbuf_q  <= '{default: '0};
      xhat_q  <= '{default: '0};
      t2_q    <= '{default: '0};
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      nbuf_q  <= nbuf_d;
      xhat_q  <= xhat_d;
      t2_q    <= t2_d;
      u_q     <= u_d;
    end
  end

  assign ap_ready = ready_c & ~ap_rst;
  assign ap_done  = (state_q == S_DONE);
  assign ap_idle  = (state_q == S_IDLE);
  assign xhat_0   = xhat_q[0];
  assign xhat_1   = xhat_q[1];
  assign xhat_2   = xhat_q[2];

endmodule

// File: tb/tb_estimador_state_update.sv
// Self-checking bench for estimador_state_update: three instances with
// different coefficient sets share the same stimulus, and each is compared
// against a wide-integer reference of the observer update equation.
module tb_estimador_state_update;

  localparam logic [287:0] A_DEF  = {32'h00010000, 32'h0, 32'h0, 32'h0, 32'h00010000,
                                     32'h0, 32'h0, 32'h0, 32'h00010000};
  localparam logic [95:0]  B_DEF  = 96'h0;
  localparam logic [287:0] A_HALF = {32'h00008000, 32'h0, 32'h0, 32'h0, 32'h00008000,
                                     32'h0, 32'h0, 32'h0, 32'h00008000};
  localparam logic [95:0]  B_ONE  = {3{32'h00010000}};
  localparam logic [287:0] A_MIX  = {32'h00020000, 32'h80000000, 32'h00000001,
                                     32'hFFFFC000, 32'h7FFFFFFF, 32'h00004000,
                                     32'hFFFE8000, 32'h00012345, 32'h80000000};
  localparam logic [95:0]  B_MIX  = {32'h80000000, 32'hFFFF0000, 32'h00010000};

  logic        ap_clk, ap_rst, ap_start, init_vld;
  logic [31:0] temp2_0, temp2_1, temp2_2, u_in, init_0, init_1, init_2;
  logic [2:0]  done_o, idle_o, ready_o;
  logic [31:0] xo [3][3];

  logic [287:0] a_tab [3];
  logic [95:0]  b_tab [3];
  logic [31:0]  mx [3][3];

  int checks   = 0;
  int failures = 0;

  estimador_state_update #(.A_COEFS(A_DEF), .B_COEFS(B_DEF)) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done_o[0]), .ap_idle(idle_o[0]), .ap_ready(ready_o[0]),
    .temp2_0(temp2_0), .temp2_1(temp2_1), .temp2_2(temp2_2), .u_in(u_in),
    .init_vld(init_vld), .init_0(init_0), .init_1(init_1), .init_2(init_2),
    .xhat_0(xo[0][0]), .xhat_1(xo[0][1]), .xhat_2(xo[0][2]));

  estimador_state_update #(.A_COEFS(A_HALF), .B_COEFS(B_ONE)) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done_o[1]), .ap_idle(idle_o[1]), .ap_ready(ready_o[1]),
    .temp2_0(temp2_0), .temp2_1(temp2_1), .temp2_2(temp2_2), .u_in(u_in),
    .init_vld(init_vld), .init_0(init_0), .init_1(init_1), .init_2(init_2),
    .xhat_0(xo[1][0]), .xhat_1(xo[1][1]), .xhat_2(xo[1][2]));

  estimador_state_update #(.A_COEFS(A_MIX), .B_COEFS(B_MIX)) dut2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done_o[2]), .ap_idle(idle_o[2]), .ap_ready(ready_o[2]),
    .temp2_0(temp2_0), .temp2_1(temp2_1), .temp2_2(temp2_2), .u_in(u_in),
    .init_vld(init_vld), .init_0(init_0), .init_1(init_1), .init_2(init_2),
    .xhat_0(xo[2][0]), .xhat_1(xo[2][1]), .xhat_2(xo[2][2]));

  // Free-running clock
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Hard stop in case something stalls the main sequence
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic signed [127:0] sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  // Reference row update: exact integer sum, round half up, clamp to int32
  function automatic logic [31:0] modelRow(input logic [287:0] a, input logic [95:0] b,
                                           input int i, input logic [31:0] x0, x1, x2,
                                           input logic [31:0] uu, t2);
    logic signed [127:0] s;
    logic signed [127:0] r;
    s = sx(a[32*(3*i) +: 32]) * sx(x0) + sx(a[32*(3*i+1) +: 32]) * sx(x1)
      + sx(a[32*(3*i+2) +: 32]) * sx(x2) + sx(b[32*i +: 32]) * sx(uu)
      + sx(t2) * 128'sd65536;
    r = (s + 128'sd32768) >>> 16;
    if (r > 128'sd2147483647) return 32'h7FFFFFFF;
    if (r < -128'sd2147483648) return 32'h80000000;
    return r[31:0];
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 4))
      0:       return 32'h80000000;
      1:       return 32'h7FFFFFFF;
      2:       return $urandom_range(0, 32'h3FFFF);
      3:       return 32'hFFFFFFFF - $urandom_range(0, 32'h3FFFF);
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Load an initial state in IDLE, optionally colliding with ap_start
  task automatic loadInit(input logic [31:0] v0, v1, v2, input logic withStart);
    init_0 = v0; init_1 = v1; init_2 = v2;
    init_vld = 1'b1;
    ap_start = withStart;
    #1;
    checkOutput("ready_during_init", {29'd0, ready_o}, 32'd0);
    tick();
    init_vld = 1'b0;
    ap_start = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      mx[d][0] = v0; mx[d][1] = v1; mx[d][2] = v2;
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("init_x%0d_%0d", d, i), xo[d][i], mx[d][i]);
    end
    checkOutput("init_idle", {29'd0, idle_o}, 32'd7);
    checkOutput("init_done", {29'd0, done_o}, 32'd0);
  endtask

  // One update request; optional busy pokes and a mid-operation reset
  task automatic applyStimulus(input logic [31:0] t0, t1, t2, uu,
                               input int pokeStart, input int pokeInit, input int rstAt);
    logic [31:0] exp [3][3];
    int doneAt, doneCnt, readyExtra, busyIdleErr;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 3; i++)
        exp[d][i] = modelRow(a_tab[d], b_tab[d], i, mx[d][0], mx[d][1], mx[d][2], uu,
                             (i == 0) ? t0 : (i == 1) ? t1 : t2);
    temp2_0 = t0; temp2_1 = t1; temp2_2 = t2; u_in = uu;
    init_vld = 1'b0;
    ap_start = 1'b1;
    #1;
    checkOutput("ready_accept", {29'd0, ready_o}, 32'd7);
    doneAt = -1; doneCnt = 0; readyExtra = 0; busyIdleErr = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      ap_start = (c == pokeStart);
      init_vld = (c == pokeInit);
      init_0 = $urandom; init_1 = $urandom; init_2 = $urandom;
      temp2_0 = $urandom; temp2_1 = $urandom; temp2_2 = $urandom; u_in = $urandom;
      ap_rst = (c == rstAt);
      #1;
      if (ready_o != 3'b000) readyExtra++;
      if (c < 17 && (rstAt < 0 || c <= rstAt) && idle_o != 3'b000) busyIdleErr++;
      if (done_o[0]) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = c;
          checkOutput("x_at_done", xo[0][0], exp[0][0]);
        end
      end
      if (rstAt >= 0 && c == rstAt + 1) begin
        checkOutput("rst_idle", {29'd0, idle_o}, 32'd7);
        for (int d = 0; d < 3; d++)
          for (int i = 0; i < 3; i++)
            checkOutput($sformatf("rst_x%0d_%0d", d, i), xo[d][i], 32'd0);
      end
    end
    ap_start = 1'b0; init_vld = 1'b0; ap_rst = 1'b0;
    checkOutput("ready_extra", readyExtra, 32'd0);
    checkOutput("idle_busy", busyIdleErr, 32'd0);
    if (rstAt < 0) begin
      checkOutput("done_cycle", doneAt, 32'd17);
      checkOutput("done_count", doneCnt, 32'd1);
    end else begin
      checkOutput("done_after_rst", doneCnt, 32'd0);
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < 3; i++) exp[d][i] = 32'd0;
    end
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 3; i++) begin
        mx[d][i] = exp[d][i];
        checkOutput($sformatf("x%0d_%0d", d, i), xo[d][i], exp[d][i]);
      end
  endtask

  // Main sequence: reset, directed cases, collisions, random updates, reset mid-flight
  initial begin
    a_tab[0] = A_DEF;  b_tab[0] = B_DEF;
    a_tab[1] = A_HALF; b_tab[1] = B_ONE;
    a_tab[2] = A_MIX;  b_tab[2] = B_MIX;
    ap_rst = 1'b1; ap_start = 1'b0; init_vld = 1'b0;
    temp2_0 = '0; temp2_1 = '0; temp2_2 = '0; u_in = '0;
    init_0 = '0; init_1 = '0; init_2 = '0;
    repeat (3) tick();
    ap_rst = 1'b0;
    #1;
    checkOutput("reset_idle", {29'd0, idle_o}, 32'd7);
    checkOutput("reset_done", {29'd0, done_o}, 32'd0);
    checkOutput("reset_ready", {29'd0, ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("reset_x0_%0d", i), xo[0][i], 32'd0);

    loadInit(32'h00010000, 32'hFFFF0000, 32'h00008000, 1'b0);

    loadInit(32'h00010000, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h00020000, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, -1, -1, -1);
    checkOutput("basic_x0", xo[0][0], 32'h00030000);
    checkOutput("basic_x1", xo[0][1], 32'h00000001);
    checkOutput("basic_x2", xo[0][2], 32'hFFFFFFFF);

    loadInit(32'h3, 32'h3, 32'h3, 1'b0);
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h00010000, -1, -1, -1);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("round_x%0d", i), xo[1][i], 32'h00010002);

    loadInit(32'h7FFF0000, 32'h80010000, 32'h0, 1'b0);
    applyStimulus(32'h00020000, 32'hFFFE0000, 32'h0, 32'h0, -1, -1, -1);
    checkOutput("sat_hi", xo[0][0], 32'h7FFFFFFF);
    checkOutput("sat_lo", xo[0][1], 32'h80000000);

    loadInit(32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, -1, -1, -1);

    applyStimulus(32'h00001234, 32'hFFFF8000, 32'h00050000, 32'h00020000, 3, 8, -1);

    loadInit(32'h00120000, 32'hFFEE0000, 32'h00000777, 1'b1);
    repeat (3) begin
      tick();
      checkOutput("collide_done", {29'd0, done_o}, 32'd0);
    end

    for (int n = 0; n < 16; n++) begin
      if (n % 4 == 0) loadInit(rv(), rv(), rv(), 1'b0);
      applyStimulus(rv(), rv(), rv(), rv(), -1, -1, -1);
    end

    applyStimulus($urandom, $urandom, $urandom, $urandom, -1, -1, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/estimador_state_update.md
Name: estimador_state_update

Overview:
- Observer state-update stage, directly downstream of the gain-row loop that produces the three correction terms temp2_V_0/1/2 (Q16.16).
- Each accepted start computes, for each row i:
  - x_next[i] = sat( sum_j A[i][j]*xhat[j] + B[i]*u + temp2[i] ), all in Q16.16.
- Holds the estimated state vector internally and presents it to the next MPC stage.
- Uses one shared 32x32 signed multiplier, time-multiplexed by a row/term FSM.

Parameters:
- A_COEFS, 288-bit, default identity (0x00010000 on the diagonal, 0 elsewhere): nine signed Q16.16 words, word k = A[k/3][k%3], with word 0 in bits [31:0].
- B_COEFS, 96-bit, default 0: three signed Q16.16 words, word i = B[i], with word 0 in bits [31:0].

Ports:
- ap_clk  in  1  clock; every register updates on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ap_start  in  1  request one update; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse; new xhat values are valid in that cycle.
- ap_idle  out  1  high when in IDLE.
- ap_ready  out  1  high in the cycle ap_start is accepted.
- temp2_0, temp2_1, temp2_2  in  32 each  signed Q16.16 correction terms.
- u_in  in  32  signed Q16.16 applied control input.
- init_vld  in  1  load initial state; honoured only in IDLE.
- init_0, init_1, init_2  in  32 each  signed Q16.16 initial state.
- xhat_0, xhat_1, xhat_2  out  32 each  current state estimate (registered).

Behaviour:
- Reset (synchronous, ap_rst=1 at a clock edge):
  - xhat_0..2 = 0, ap_done = 0, ap_ready = 0, ap_idle = 1.
  - FSM goes to IDLE; accumulator, counters and next-state buffer clear.
  - Reset overrides any operation in progress; a partially computed update is discarded and xhat is zeroed.
- FSM states: IDLE, MAC, FIN, COMMIT, DONE.
- IDLE:
  - init_vld=1: load xhat <= init_0..2. Any ap_start in the same cycle is ignored (ap_ready stays 0).
  - else ap_start=1: latch temp2_0..2 and u_in, set ap_ready=1, clear acc, row=0, term=0, go to MAC.
  - ap_start and init_vld are ignored in every other state.
- MAC (term 0..3, one cycle each):
  - Terms 0..2: acc += A[row][term]*xhat[term].
  - Term 3: acc += B[row]*u_latched.
  - Each product is a full 64-bit signed value; acc is 68-bit signed. After term 3, go to FIN.
- FIN (one cycle):
  - t = acc + (sign-extended temp2[row] << 16).
  - r = (t >>> 16) + t[15]  (round half up, computed at 53 bits).
  - Result = 0x7FFFFFFF if r > 2^31-1; 0x80000000 if r < -2^31; else r[31:0].
  - Write result to nbuf[row], clear acc.
  - row < 2: row++, term=0, go to MAC. row = 2: go to COMMIT.
- COMMIT: xhat_0..2 <= nbuf_0..2 simultaneously, then go to DONE.
  - xhat is never partially updated. All rows use the old xhat during computation (Jacobi-style, not Gauss-Seidel).
- DONE: ap_done=1 for exactly one cycle, then IDLE. ap_idle=0 in every state except IDLE.
- Timing, with ap_start accepted in cycle T:
  - MAC row0 T+1..T+4, FIN T+5; MAC row1 T+6..T+9, FIN T+10; MAC row2 T+11..T+14, FIN T+15.
  - COMMIT T+16.
  - DONE T+17: ap_done=1, new xhat visible.
  - Earliest next accept: T+18. Fixed latency of 17 cycles, independent of data.
- Inputs temp2_*/u_in may change after the accept cycle without effect.
- Arithmetic: all quantities two's-complement. A coefficient of 0x80000000 times a state of 0x80000000 must be accumulated without overflow; the 68-bit acc guarantees this.

Test Plan:
- Reset/init: reset, then init_vld with init = {0x00010000, 0xFFFF0000, 0x00008000} -> xhat equals init next cycle; ap_done stays 0.
- Default parameters, xhat={0x00010000,0,0}, temp2={0x00020000,0x00000001,0xFFFFFFFF}, start at T -> ap_done only at T+17; xhat={0x00030000,0x00000001,0xFFFFFFFF}; ap_ready=1 only at T.
- A=diag 0x00008000, B=0x00010000 all rows, u=0x00010000, xhat=0x00000003 each row, temp2=0 -> 3*0.5 = 1.5 LSB rounds up to 2; result 0x00010002 per row.
- Saturation: default A, xhat_0=0x7FFF0000, temp2_0=0x00020000 -> xhat_0=0x7FFFFFFF. xhat_1=0x80010000, temp2_1=0xFFFE0000 -> xhat_1=0x80000000.
- Busy and collision: ap_start pulsed at T+3 and init_vld at T+8 -> both ignored, one ap_done at T+17. Start and init together in IDLE -> init loaded, no ap_ready.
- Reset mid-operation: ap_rst at T+9 -> next cycle xhat=0 and ap_idle=1; no ap_done follows.
